// File: rtl/imem_writer_pkg.sv
// Shared processor definitions: instruction kinds, field widths and the
// major-opcode constants used by both the encoder and the decoder.
package imem_writer_pkg;

    localparam int unsigned REG_W  = 2;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned IMM_W  = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned KIND_W = 3;

    typedef enum logic [KIND_W-1:0] {
        KIND_NOP  = 3'd0,
        KIND_HALT = 3'd1,
        KIND_CALR = 3'd2,
        KIND_CALI = 3'd3,
        KIND_LIL  = 3'd4,
        KIND_LIH  = 3'd5,
        KIND_LM   = 3'd6,
        KIND_SM   = 3'd7
    } instr_kind_t;

    // Major opcodes occupy word bits 15..13; LIL and LIH share one and
    // differ only in bit 12.
    localparam logic [2:0] MAJ_CALR = 3'b000;
    localparam logic [2:0] MAJ_CALI = 3'b001;
    localparam logic [2:0] MAJ_LI   = 3'b010;
    localparam logic [2:0] MAJ_LM   = 3'b100;
    localparam logic [2:0] MAJ_SM   = 3'b101;

    localparam int unsigned LI_HI_BIT    = 12;
    localparam int unsigned CALR_TAG_BIT = 2;

    localparam logic [WORD_W-1:0] WORD_NOP  = 16'h0000;
    localparam logic [WORD_W-1:0] WORD_HALT = 16'h0001;

endpackage

// File: rtl/imem_writer_enc.sv
// Combinational instruction encoder: instruction kind plus fields to the
// 16-bit instruction word; fields a kind does not use are ignored.
module instr_enc
    import imem_writer_pkg::*;
(
    input  logic [KIND_W-1:0] kind,
    input  logic [REG_W-1:0]  rw,
    input  logic [REG_W-1:0]  ra,
    input  logic [REG_W-1:0]  rb,
    input  logic [OP_W-1:0]   op,
    input  logic              o,
    input  logic [IMM_W-1:0]  im,
    output logic [WORD_W-1:0] word
);

    always_comb begin
        word = '0;
        case (instr_kind_t'(kind))
            KIND_NOP:  word = WORD_NOP;
            KIND_HALT: word = WORD_HALT;
            KIND_CALR: begin
                word[15:13]        = MAJ_CALR;
                word[11:10]        = rw;
                word[9:8]          = ra;
                word[6:4]          = op;
                word[CALR_TAG_BIT] = 1'b1;
                word[1:0]          = rb;
            end
            KIND_CALI: word = {MAJ_CALI, o, rw, ra, im};
            KIND_LIL:  word = {MAJ_LI, 1'b0, rw, rb, im};
            KIND_LIH: begin
                word            = {MAJ_LI, 1'b0, rw, rb, im};
                word[LI_HI_BIT] = 1'b1;
            end
            KIND_LM:   word = {MAJ_LM, o, rw, ra, im};
            KIND_SM:   word = {MAJ_SM, o, rb, ra, im};
            default:   word = '0;
        endcase
    end

endmodule

// File: rtl/imem_writer.sv
// Program loader: accepts instruction beats, encodes them and writes them to
// consecutive instruction-memory addresses until HALT or memory is full.
module imem_writer
    import imem_writer_pkg::*;
#(
    parameter int unsigned IMEM_AW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KIND_W-1:0]   in_kind,
    input  logic [REG_W-1:0]    in_rw,
    input  logic [REG_W-1:0]    in_ra,
    input  logic [REG_W-1:0]    in_rb,
    input  logic [OP_W-1:0]     in_op,
    input  logic                in_o,
    input  logic [IMM_W-1:0]    in_im,
    output logic                imem_we,
    output logic [IMEM_AW-1:0]  imem_adr,
    output logic [WORD_W-1:0]   imem_wd,
    output logic                busy,
    output logic                done,
    output logic [IMEM_AW:0]    count,
    output logic                err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [IMEM_AW-1:0] PTR_ONE = 1;
    localparam logic [IMEM_AW:0]   CNT_ONE = 1;

    logic [1:0]          state;
    logic [IMEM_AW-1:0]  wr_ptr;
    logic [WORD_W-1:0]   enc_word;
    logic                accept;
    logic                is_halt;
    logic                last_slot;

    instr_enc u_enc (
        .kind (in_kind),
        .rw   (in_rw),
        .ra   (in_ra),
        .rb   (in_rb),
        .op   (in_op),
        .o    (in_o),
        .im   (in_im),
        .word (enc_word)
    );

    assign in_ready  = (state == ST_RUN);
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign is_halt   = (in_kind == KIND_HALT);
    assign last_slot = &wr_ptr;

    // The write port is a pure register stage: a beat accepted on one edge
    // appears on imem_* for exactly the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            imem_we  <= 1'b0;
            imem_adr <= '0;
            imem_wd  <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            imem_we <= accept;
            if (accept) begin
                imem_adr <= wr_ptr;
                imem_wd  <= enc_word;
                count    <= count + CNT_ONE;
                if (!last_slot) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (last_slot && !is_halt) begin
                    err <= 1'b1;
                end
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        wr_ptr <= '0;
                        count  <= '0;
                        err    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Filling the last slot ends the load even without HALT,
                    // so the pointer never wraps onto address 0.
                    if (accept && (is_halt || last_slot)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_writer.sv
// Directed bench for imem_writer: encodings, handshake, load termination,
// overflow and asynchronous reset behaviour.
module tb_imem_writer;
    import imem_writer_pkg::*;

    localparam int unsigned AW = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [1:0]        in_rw;
    logic [1:0]        in_ra;
    logic [1:0]        in_rb;
    logic [2:0]        in_op;
    logic              in_o;
    logic [7:0]        in_im;
    logic              imem_we;
    logic [AW-1:0]     imem_adr;
    logic [15:0]       imem_wd;
    logic              busy;
    logic              done;
    logic [AW:0]       count;
    logic              err;

    int unsigned n_checks;
    int unsigned n_errors;

    imem_writer #(.IMEM_AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_kind  (in_kind),
        .in_rw    (in_rw),
        .in_ra    (in_ra),
        .in_rb    (in_rb),
        .in_op    (in_op),
        .in_o     (in_o),
        .in_im    (in_im),
        .imem_we  (imem_we),
        .imem_adr (imem_adr),
        .imem_wd  (imem_wd),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one beat for one edge; returns #1 after that edge.
    task automatic beat(input logic [2:0] k, input logic [1:0] rw, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [2:0] op, input logic o,
                        input logic [7:0] im);
        in_kind  = k;
        in_rw    = rw;
        in_ra    = ra;
        in_rb    = rb;
        in_op    = op;
        in_o     = o;
        in_im    = im;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [AW-1:0] adr, input logic [15:0] wd);
        check({tag, "_we"}, {31'b0, imem_we}, 32'd1);
        check({tag, "_adr"}, {24'b0, imem_adr}, {24'b0, adr});
        check({tag, "_wd"}, {16'b0, imem_wd}, {16'b0, wd});
    endtask

    task automatic halt_and_finish(input string tag, input logic [AW-1:0] adr);
        beat(KIND_HALT, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 8'd0);
        expect_write(tag, adr, 16'h0001);
        check({tag, "_drain_rdy"}, {31'b0, in_ready}, 32'd0);
        tick();
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_done_we"}, {31'b0, imem_we}, 32'd0);
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_rdy"}, {31'b0, in_ready}, 32'd0);
        check({tag, "_we"}, {31'b0, imem_we}, 32'd0);
        check({tag, "_adr"}, {24'b0, imem_adr}, 32'd0);
        check({tag, "_wd"}, {16'b0, imem_wd}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_count"}, {23'b0, count}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_kind  = '0;
        in_rw    = '0;
        in_ra    = '0;
        in_rb    = '0;
        in_op    = '0;
        in_o     = 1'b0;
        in_im    = '0;

        tick();
        tick();
        all_zero("rst");
        rst_n = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("idle_no_write", {31'b0, imem_we}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);

        // CALR, then HALT
        pulse_start();
        check("run_rdy", {31'b0, in_ready}, 32'd1);
        check("run_busy", {31'b0, busy}, 32'd1);
        beat(KIND_CALR, 2'd2, 2'd1, 2'd3, 3'd5, 1'b0, 8'h00);
        expect_write("calr", 8'd0, 16'h0957);
        halt_and_finish("calr_halt", 8'd1);

        // LIH, LIL back to back
        pulse_start();
        beat(KIND_LIH, 2'd1, 2'd0, 2'd2, 3'd0, 1'b0, 8'hA5);
        expect_write("lih", 8'd0, 16'h56A5);
        beat(KIND_LIL, 2'd3, 2'd0, 2'd0, 3'd0, 1'b0, 8'h12);
        expect_write("lil", 8'd1, 16'h4C12);
        halt_and_finish("li_halt", 8'd2);

        // LM, SM, CALI with gaps; a start in RUN must not restart the load
        pulse_start();
        beat(KIND_LM, 2'd1, 2'd2, 2'd0, 3'd0, 1'b0, 8'hFF);
        expect_write("lm", 8'd0, 16'h86FF);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("gap1_we", {31'b0, imem_we}, 32'd0);
        beat(KIND_SM, 2'd0, 2'd3, 2'd2, 3'd0, 1'b1, 8'h04);
        expect_write("sm", 8'd1, 16'hBB04);
        tick();
        check("gap2_we", {31'b0, imem_we}, 32'd0);
        beat(KIND_CALI, 2'd0, 2'd1, 2'd0, 3'd0, 1'b1, 8'h7F);
        expect_write("cali", 8'd2, 16'h317F);
        halt_and_finish("mix_halt", 8'd3);

        // NOP, HALT then reload
        pulse_start();
        beat(KIND_NOP, 2'd3, 2'd3, 2'd3, 3'd7, 1'b1, 8'hFF);
        expect_write("nop", 8'd0, 16'h0000);
        halt_and_finish("nh", 8'd1);
        check("nh_count", {23'b0, count}, 32'd2);
        check("nh_err", {31'b0, err}, 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("done_ignore_valid", {31'b0, imem_we}, 32'd0);
        check("done_hold_wd", {16'b0, imem_wd}, 32'h0001);
        pulse_start();
        check("reload_count", {23'b0, count}, 32'd0);
        beat(KIND_CALI, 2'd0, 2'd1, 2'd0, 3'd0, 1'b1, 8'h7F);
        expect_write("reload", 8'd0, 16'h317F);
        halt_and_finish("reload_halt", 8'd1);

        // 256 NOPs without HALT: capacity exhausted
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            beat(KIND_NOP, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 8'd0);
            check("fill_adr", {24'b0, imem_adr}, i);
        end
        check("fill_last_we", {31'b0, imem_we}, 32'd1);
        check("fill_err", {31'b0, err}, 32'd1);
        check("fill_drain_rdy", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1;
        tick();
        check("fill_done", {31'b0, done}, 32'd1);
        check("fill_no_extra", {31'b0, imem_we}, 32'd0);
        check("fill_count", {23'b0, count}, 32'd256);
        check("fill_err_hold", {31'b0, err}, 32'd1);
        check("fill_adr_hold", {24'b0, imem_adr}, 32'd255);
        in_valid = 1'b0;
        pulse_start();
        check("fill_err_clr", {31'b0, err}, 32'd0);

        // Reset mid-load
        for (int i = 0; i < 3; i++) begin
            beat(KIND_LIL, 2'd1, 2'd0, 2'd1, 3'd0, 1'b0, 8'h33);
        end
        check("pre_rst_adr", {24'b0, imem_adr}, 32'd2);
        in_kind  = KIND_LIL;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        all_zero("arst");
        tick();
        tick();
        check("arst_held_we", {31'b0, imem_we}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_we", {31'b0, imem_we}, 32'd0);
        check("rel_busy", {31'b0, busy}, 32'd0);
        in_valid = 1'b0;
        pulse_start();
        beat(KIND_LIH, 2'd1, 2'd0, 2'd2, 3'd0, 1'b0, 8'hA5);
        expect_write("post_rst", 8'd0, 16'h56A5);
        halt_and_finish("post_rst_halt", 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_writer.md
IMEM_WRITER -- requirements
Module: imem_writer

Interface
REQ-001 Parameter: IMEM_AW, default 8, instruction-memory address width; program capacity 2**IMEM_AW words.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 start  input  1  begin or restart a program load; sampled in IDLE and DONE only.
REQ-005 in_valid  input  1  instruction beat present.
REQ-006 in_ready  output  1  writer accepts beat; transfer when in_valid && in_ready.
REQ-007 in_kind  input  3  instr_kind_t: NOP, HALT, CALR, CALI, LIL, LIH, LM, SM.
REQ-008 in_rw, in_ra, in_rb  input  2 each  write/A/B register addresses.
REQ-009 in_op  input  3  ALU op (CALR only).
REQ-010 in_o  input  1  ADD/SUB select (CALI, LM, SM).
REQ-011 in_im  input  8  immediate.
REQ-012 imem_we  output  1  instruction-memory write strobe.
REQ-013 imem_adr  output  IMEM_AW  write address.
REQ-014 imem_wd  output  16  encoded instruction word.
REQ-015 busy  output  1  high in RUN and DRAIN.
REQ-016 done  output  1  high in DONE.
REQ-017 count  output  IMEM_AW+1  words written in current load.
REQ-018 err  output  1  capacity exhausted without HALT; sticky until start.

Function
REQ-019 Encoding (bits F..0) SHALL be: NOP 0x0000; HALT 0x0001; CALR 000,0,rw,ra,0,op,0,1,rb; CALI 001,o,rw,ra,im; LIL 0100,rw,rb,im; LIH 0101,rw,rb,im; LM 100,o,rw,ra,im; SM 101,o,rb,ra,im; unused fields ignored.
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-021 IDLE: in_ready=0; start -> RUN, address counter and count cleared, err cleared.
REQ-022 RUN: in_ready=1; each accepted beat SHALL be encoded and registered, giving imem_we=1, imem_wd, imem_adr exactly one cycle after acceptance.
REQ-023 Write addresses SHALL be 0,1,2,... in acceptance order; count increments on every imem_we.
REQ-024 Accepting HALT SHALL move RUN -> DRAIN; the HALT word is still written.
REQ-025 Accepting the beat at address 2**IMEM_AW-1 that is not HALT SHALL move RUN -> DRAIN and set err on the following cycle; no address wrap occurs.
REQ-026 DRAIN: in_ready=0, final write completes, -> DONE next cycle.
REQ-027 DONE: in_ready=0, outputs held; start -> RUN with counters and err cleared.
REQ-028 start in RUN or DRAIN SHALL be ignored; in_valid outside RUN SHALL be ignored.
REQ-029 in_valid gaps in RUN SHALL produce no write (imem_we=0) and no address advance.
REQ-030 imem_we SHALL never be asserted for two writes to the same address in one load.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, in_ready=0, imem_we=0, imem_adr=0, imem_wd=0, busy=0, done=0, count=0, err=0.
REQ-032 Reset mid-load SHALL drop any pending write; no write occurs on the cycle reset is released.

Structure
REQ-033 instr_kind_t, opcode field constants (3-bit major opcodes, LIL/LIH bit 12, CALR bit 2), field widths (register 2, op 3, immediate 8, word 16) SHALL live in the shared processor package used by the decoder.
REQ-034 Encoding SHALL be one combinational sub-module, instr_enc (kind+fields -> 16-bit word), instantiated once; FSM, counters and output register in imem_writer.

Verification
REQ-035 start; CALR rw=2 ra=1 rb=3 op=5 -> next cycle imem_we=1, imem_adr=0, imem_wd=0x0957.
REQ-036 LIH rw=1 rb=2 im=0xA5, LIL rw=3 rb=0 im=0x12, back-to-back -> 0x56A5@0, 0x4C12@1 on consecutive cycles.
REQ-037 LM o=0 rw=1 ra=2 im=0xFF; SM o=1 rb=2 ra=3 im=0x04; CALI o=1 rw=0 ra=1 im=0x7F, with one-cycle in_valid gaps -> 0x86FF@0, 0xBB04@1, 0x317F@2, no write in gaps.
REQ-038 NOP, HALT -> 0x0000@0, 0x0001@1, in_ready low after HALT accept, done=1 one cycle after last write, count=2, err=0; repeated start reloads from address 0.
REQ-039 256 NOPs, no HALT -> last write @255, err=1, done=1, count=256.
REQ-040 rst_n low during RUN after 3 accepted beats -> all outputs 0 immediately, no further write; start after release writes from address 0.
